// File: rtl/pixel_pkg.sv
// Shared types and constants for the per-pixel layer compositor.
package pixel_pkg;
    localparam int SPR_W  = 32;
    localparam int SPR_H  = 32;
    localparam int BG_W   = 320;
    localparam int SPR_XB = $clog2(SPR_W);
    localparam int SPR_YB = $clog2(SPR_H);
    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

    typedef enum logic [2:0] {
        AREA   = 3'd0,
        FOREST = 3'd1,
        KIRBY  = 3'd2,
        ENEMY  = 3'd3,
        START  = 3'd4
    } pal_sel_t;

    typedef enum logic [1:0] {
        SCN_AREA   = 2'd0,
        SCN_FOREST = 2'd1,
        SCN_START  = 2'd2,
        SCN_RSVD   = 2'd3
    } scene_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;
endpackage

// File: rtl/pixel_layer_fetch_sprite_window.sv
// Sprite hit test and ROM address for one sprite at the current draw position.
module sprite_window import pixel_pkg::*; (
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic       mirror,
    input  logic       enable,
    output logic       hit,
    output logic [9:0] addr
);
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic [SPR_XB-1:0] col;

    assign dx = {1'b0, draw_x} - {1'b0, pos_x};
    assign dy = {1'b0, draw_y} - {1'b0, pos_y};

    // A negative offset sets the sign bit, so one unsigned compare covers both bounds.
    assign hit  = enable && (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
    assign col  = mirror ? ~dx[SPR_XB-1:0] : dx[SPR_XB-1:0];
    assign addr = hit ? 10'({dy[SPR_YB-1:0], col}) : '0;
endmodule

// File: rtl/pixel_layer_fetch.sv
// Layer compositor: drives sprite/background ROM addresses and resolves priority, 3-cycle latency.
module pixel_layer_fetch import pixel_pkg::*; (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        in_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic [1:0]  scene,
    input  logic [9:0]  kirby_x,
    input  logic [9:0]  kirby_y,
    input  logic        kirby_left,
    input  logic [9:0]  enemy_x,
    input  logic [9:0]  enemy_y,
    input  logic        enemy_alive,
    output logic [16:0] bg_addr,
    output logic [9:0]  kirby_addr,
    output logic [9:0]  enemy_addr,
    input  logic [3:0]  bg_data,
    input  logic [3:0]  kirby_data,
    input  logic [3:0]  enemy_data,
    output logic        out_valid,
    output logic [3:0]  pix_idx,
    output pal_sel_t    pal_sel
);
    scene_t     lat_scene;
    pos_t       lat_k, lat_e;
    logic       lat_kleft, lat_ealive;

    // The latch is a register, so a pixel in the same cycle as frame_start sees the old scene.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lat_scene  <= SCN_AREA;
            lat_k      <= '0;
            lat_e      <= '0;
            lat_kleft  <= 1'b0;
            lat_ealive <= 1'b0;
        end else if (frame_start) begin
            lat_scene  <= scene_t'(scene);
            lat_k      <= '{x: kirby_x, y: kirby_y};
            lat_e      <= '{x: enemy_x, y: enemy_y};
            lat_kleft  <= kirby_left;
            lat_ealive <= enemy_alive;
        end
    end

    logic       k_hit, e_hit;
    logic [9:0] k_addr, e_addr;
    logic [16:0] bg_addr_d;

    sprite_window u_kirby (
        .pos_x(lat_k.x), .pos_y(lat_k.y), .draw_x(DrawX), .draw_y(DrawY),
        .mirror(lat_kleft), .enable(1'b1), .hit(k_hit), .addr(k_addr)
    );

    sprite_window u_enemy (
        .pos_x(lat_e.x), .pos_y(lat_e.y), .draw_x(DrawX), .draw_y(DrawY),
        .mirror(1'b0), .enable(lat_ealive), .hit(e_hit), .addr(e_addr)
    );

    assign bg_addr_d = 17'(DrawY[9:1]) * 17'(BG_W) + 17'(DrawX[9:1]);

    logic [2:0] vld_pipe;
    logic [1:0] hit_s1, hit_s2;
    scene_t     scn_s1, scn_s2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_pipe   <= '0;
            bg_addr    <= '0;
            kirby_addr <= '0;
            enemy_addr <= '0;
            hit_s1     <= '0;
            hit_s2     <= '0;
            scn_s1     <= SCN_AREA;
            scn_s2     <= SCN_AREA;
        end else begin
            vld_pipe   <= {vld_pipe[1:0], in_valid};
            bg_addr    <= bg_addr_d;
            kirby_addr <= k_addr;
            enemy_addr <= e_addr;
            hit_s1     <= {k_hit, e_hit};
            scn_s1     <= lat_scene;
            hit_s2     <= hit_s1;
            scn_s2     <= scn_s1;
        end
    end

    pal_sel_t   sel_d;
    logic [3:0] idx_d;

    always_comb begin
        sel_d = (scn_s2 == SCN_FOREST) ? FOREST : AREA;
        idx_d = bg_data;
        if (scn_s2 == SCN_START) begin
            sel_d = START;
        end else if (hit_s2[1] && kirby_data != TRANSPARENT_IDX) begin
            sel_d = KIRBY;
            idx_d = kirby_data;
        end else if (hit_s2[0] && enemy_data != TRANSPARENT_IDX) begin
            sel_d = ENEMY;
            idx_d = enemy_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_idx <= '0;
            pal_sel <= AREA;
        end else if (vld_pipe[1]) begin
            pix_idx <= idx_d;
            pal_sel <= sel_d;
        end
    end

    assign out_valid = vld_pipe[2];
endmodule

// File: tb/tb_pixel_layer_fetch.sv
// Directed bench for pixel_layer_fetch with queued expectations checked by a free-running monitor.
module tb_pixel_layer_fetch;
    import pixel_pkg::*;

    logic        Clk, Reset_n, in_valid, frame_start;
    logic [9:0]  DrawX, DrawY, kirby_x, kirby_y, enemy_x, enemy_y;
    logic [1:0]  scene;
    logic        kirby_left, enemy_alive;
    logic [16:0] bg_addr;
    logic [9:0]  kirby_addr, enemy_addr;
    logic [3:0]  bg_data, kirby_data, enemy_data;
    logic        out_valid;
    logic [3:0]  pix_idx;
    pal_sel_t    pal_sel;

    pixel_layer_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(frame_start), .scene(scene), .kirby_x(kirby_x), .kirby_y(kirby_y),
        .kirby_left(kirby_left), .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_alive(enemy_alive),
        .bg_addr(bg_addr), .kirby_addr(kirby_addr), .enemy_addr(enemy_addr),
        .bg_data(bg_data), .kirby_data(kirby_data), .enemy_data(enemy_data),
        .out_valid(out_valid), .pix_idx(pix_idx), .pal_sel(pal_sel)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM models: background returns the low address nibble, sprites return a per-test constant.
    logic [3:0] k_rom, e_rom;
    always @(posedge Clk) begin
        bg_data    <= bg_addr[3:0];
        kirby_data <= k_rom;
        enemy_data <= e_rom;
    end

    typedef struct { logic [3:0] pix; pal_sel_t pal; } out_exp_t;
    typedef struct { logic [16:0] b; logic [9:0] k; logic [9:0] e; } addr_exp_t;
    out_exp_t  out_q[$];
    addr_exp_t addr_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic vd1;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) vd1 <= 1'b0;
        else          vd1 <= in_valid;
    end

    always @(negedge Clk) begin
        if (Reset_n && vd1) begin
            if (addr_q.size() == 0) chk("addr_q_size", addr_q.size(), 1);
            else begin
                addr_exp_t a;
                a = addr_q.pop_front();
                chk("bg_addr", bg_addr, a.b);
                chk("kirby_addr", kirby_addr, a.k);
                chk("enemy_addr", enemy_addr, a.e);
            end
        end
        if (out_valid) begin
            if (out_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
            else begin
                out_exp_t o;
                o = out_q.pop_front();
                chk("pix_idx", pix_idx, o.pix);
                chk("pal_sel", int'(pal_sel), int'(o.pal));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic scene_set(input int sc, input int kx, input int ky, input bit kl,
                             input int ex, input int ey, input bit ea);
        scene = 2'(sc); kirby_x = 10'(kx); kirby_y = 10'(ky); kirby_left = kl;
        enemy_x = 10'(ex); enemy_y = 10'(ey); enemy_alive = ea;
    endtask

    task automatic latch();
        frame_start = 1'b1;
        idle(1);
        frame_start = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input int epix, input pal_sel_t epal,
                       input int eb, input int ek, input int ee, input bit push_out);
        out_exp_t  o;
        addr_exp_t a;
        in_valid = 1'b1; DrawX = 10'(x); DrawY = 10'(y);
        a.b = 17'(eb); a.k = 10'(ek); a.e = 10'(ee);
        addr_q.push_back(a);
        if (push_out) begin
            o.pix = 4'(epix); o.pal = epal;
            out_q.push_back(o);
        end
        idle(1);
        in_valid = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; in_valid = 1'b0; frame_start = 1'b0; DrawX = '0; DrawY = '0;
        scene_set(0, 0, 0, 0, 0, 0, 0);
        k_rom = '0; e_rom = '0;
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        idle(2);
        @(negedge Clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pix_idx", pix_idx, 0);
        chk("rst_pal_sel", int'(pal_sel), int'(AREA));
        chk("rst_bg_addr", bg_addr, 0);
        chk("rst_kirby_addr", kirby_addr, 0);
        chk("rst_enemy_addr", enemy_addr, 0);
        idle(1);

        // Kirby opaque over area background
        scene_set(0, 100, 50, 0, 400, 300, 1); latch();
        k_rom = 4'h3; e_rom = 4'h7;
        pix(100, 50, 3, KIRBY, 8050, 0, 0, 1);
        idle(4);

        // Kirby transparent, enemy behind it shows through
        scene_set(0, 100, 50, 0, 90, 40, 1); latch();
        k_rom = 4'h0;
        pix(100, 50, 7, ENEMY, 8050, 0, 330, 1);
        idle(4);

        // Dead enemy, forest background
        scene_set(1, 100, 50, 0, 90, 40, 0); latch();
        pix(100, 50, 2, FOREST, 8050, 0, 0, 1);
        idle(4);

        // Mirrored Kirby, window corners and edges, back to back
        scene_set(1, 100, 50, 1, 90, 40, 0); latch();
        k_rom = 4'h3;
        pix(100, 50, 3, KIRBY, 8050, 31, 0, 1);
        pix(131, 81, 3, KIRBY, 12865, 992, 0, 1);
        pix(132, 50, 2, FOREST, 8066, 0, 0, 1);
        pix(99, 50, 1, FOREST, 8049, 0, 0, 1);
        pix(100, 82, 2, FOREST, 13170, 0, 0, 1);
        idle(4);

        // Start screen ignores sprites; last pixel of the frame
        scene_set(2, 100, 50, 1, 90, 40, 1); latch();
        pix(100, 50, 2, START, 8050, 31, 330, 1);
        pix(639, 479, 15, START, 76799, 0, 0, 1);
        idle(4);

        // Reserved scene renders as area
        scene_set(3, 100, 50, 1, 90, 40, 0); latch();
        pix(2, 0, 1, AREA, 1, 0, 0, 1);
        idle(4);

        // Unlatched move is ignored; coincident frame_start pixel uses the old position
        scene_set(0, 100, 50, 0, 90, 40, 0); latch();
        kirby_x = 10'd300;
        pix(100, 50, 3, KIRBY, 8050, 0, 0, 1);
        frame_start = 1'b1;
        pix(310, 55, 11, AREA, 8795, 0, 0, 1);
        frame_start = 1'b0;
        pix(310, 55, 3, KIRBY, 8795, 170, 0, 1);
        idle(4);

        // Reset with three pixels in flight: none may emerge
        pix(10, 10, 0, AREA, 1605, 0, 0, 0);
        pix(11, 10, 0, AREA, 1605, 0, 0, 0);
        in_valid = 1'b1; DrawX = 10'd12;
        @(negedge Clk);
        #1 Reset_n = 1'b0; in_valid = 1'b0;
        idle(2);
        Reset_n = 1'b1;
        idle(8);
        @(negedge Clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_pix_idx", pix_idx, 0);
        chk("post_rst_pal_sel", int'(pal_sel), int'(AREA));
        chk("out_q_leftover", out_q.size(), 0);
        chk("addr_q_leftover", addr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
